regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register data width.
REQ-002 SHALL provide parameter NREGS, default 32, register count (power of 2, 2..64); AW = clog2(NREGS).
REQ-003 SHALL provide parameter SP_INIT, default 32'h0100_0000, reset value of register 2 (stack pointer).
REQ-004 SHALL provide parameter BYPASS, default 1, 1 = writeback-to-read forwarding enabled, 0 = disabled.
REQ-005 SHALL have ports: clock  in  1  sole clock, all state updates on rising edge.
REQ-006 reset_n  in  1  reset, synchronous and active-low.
REQ-007 rs1_addr, rs2_addr  in  AW each  source register addresses of the instruction being issued.
REQ-008 rs1_data, rs2_data  out  XLEN each  combinational read data.
REQ-009 issue_valid  in  1  instruction with destination issue_rd requests issue.
REQ-010 issue_rd  in  AW  destination register of the issuing instruction.
REQ-011 stall  out  1  combinational, issue refused this cycle.
REQ-012 wb_valid  in  1  writeback valid. wb_rd  in  AW  writeback register. wb_data  in  XLEN  writeback data.
REQ-013 rs1_busy, rs2_busy  out  1 each  combinational, effective pending-write flag of each source.
REQ-014 busy_count  out  AW+1  registered count of set scoreboard bits.

Function
REQ-015 Register 0 SHALL always read 0, SHALL never be written, and SHALL never be marked busy.
REQ-016 Reads SHALL be combinational: rsN_data = regs[rsN_addr], subject to REQ-017.
REQ-017 With BYPASS=1, wb_valid=1, wb_rd=rsN_addr and rsN_addr!=0, rsN_data SHALL equal wb_data in the same cycle. With BYPASS=0, old contents are returned until the next edge.
REQ-018 Write SHALL occur at the rising edge when wb_valid=1 and wb_rd!=0: regs[wb_rd] <= wb_data.
REQ-019 Scoreboard: one busy bit per register. Effective busy(r) = busy[r] AND NOT (BYPASS=1 AND wb_valid AND wb_rd=r).
REQ-020 rsN_busy SHALL be the effective busy of rsN_addr (0 for address 0).
REQ-021 stall SHALL be issue_valid AND (rs1_busy OR rs2_busy OR effective busy(issue_rd)). A WAW hazard always stalls. stall SHALL be 0 when issue_valid=0.
REQ-022 Issue is accepted when issue_valid=1 and stall=0. On acceptance with issue_rd!=0, busy[issue_rd] SHALL be set at the edge.
REQ-023 At the edge, busy[wb_rd] SHALL be cleared when wb_valid=1.
REQ-024 Set and clear of the same register in the same edge SHALL leave the bit set (new owner wins).
REQ-025 With BYPASS=0, a same-cycle writeback SHALL NOT unblock a stall; the stall releases the following cycle.
REQ-026 A writeback to a non-busy register SHALL still write data and SHALL leave the scoreboard unchanged.
REQ-027 busy_count SHALL equal the popcount of busy[] after each edge; maximum NREGS-1.

Reset
REQ-028 While reset_n=0 at a rising edge: all registers SHALL become 0 except register 2, which SHALL become SP_INIT (truncated to XLEN). All busy bits SHALL clear and busy_count SHALL become 0.
REQ-029 Reset SHALL take priority over same-edge wb and issue. Reset mid-hazard SHALL drop all pending ownership, so stall=0 after reset.
REQ-030 After reset with no requests: rs*_busy=0, stall=0, and reading register 2 SHALL return SP_INIT.

Verification
REQ-031 Reset, then read addresses 2 and 5 -> rs1_data=32'h0100_0000, rs2_data=0, busy_count=0.
REQ-032 Issue rd=3. Next cycle issue with rs1_addr=3 -> stall=1, rs1_busy=1. Then wb rd=3 data=32'hDEAD_BEEF -> same cycle stall=0, rs1_data=32'hDEAD_BEEF (BYPASS=1). Following edge: busy_count=1 if accepted, 0 otherwise.
REQ-033 Same as REQ-032 with BYPASS=0 -> stall stays 1 in the wb cycle and rs1_data is old. Next cycle: stall=0 and rs1_data=32'hDEAD_BEEF.
REQ-034 Write 32'h1234 to register 0 and issue rd=0 -> register 0 reads 0, busy_count unchanged, stall=0.
REQ-035 Busy rd=7, same cycle wb rd=7 and accepted issue rd=7 -> busy[7] remains set, data written, busy_count unchanged.
REQ-036 Set busy on registers 1, 4 and 9, then assert reset_n=0 for one edge together with wb_valid -> all busy cleared, count 0, register 2=SP_INIT, wb write discarded.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register pending-write scoreboard.
// Reads are combinational with optional writeback forwarding; issue stalls on RAW/WAW hazards.
module regfile_scoreboard #(
    parameter int          XLEN    = 32,
    parameter int          NREGS   = 32,
    parameter logic [31:0] SP_INIT = 32'h0100_0000,
    parameter int          BYPASS  = 1,
    localparam int         AW      = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            stall,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW:0]     busy_count
);

    localparam logic [XLEN-1:0] SP_VAL = XLEN'(SP_INIT);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [NREGS-1:0] wb_hit;
    logic [NREGS-1:0] eff_busy;
    logic             accept;

    function automatic logic [AW:0] count_ones(input logic [NREGS-1:0] v);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + (AW+1)'(v[i]);
        end
        return cnt;
    endfunction

    // A writeback in flight only hides its register's busy bit when forwarding exists.
    always_comb begin
        wb_hit = '0;
        if (BYPASS != 0 && wb_valid) begin
            wb_hit[wb_rd] = 1'b1;
        end
        eff_busy = busy & ~wb_hit;
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (BYPASS != 0 && wb_valid && wb_rd == rs1_addr) rs1_data = wb_data;
        if (BYPASS != 0 && wb_valid && wb_rd == rs2_addr) rs2_data = wb_data;
        if (rs1_addr == '0) rs1_data = '0;
        if (rs2_addr == '0) rs2_data = '0;
    end

    // busy[0] is never set, so address 0 naturally reports not busy.
    assign rs1_busy = eff_busy[rs1_addr];
    assign rs2_busy = eff_busy[rs2_addr];
    assign stall    = issue_valid & (rs1_busy | rs2_busy | eff_busy[issue_rd]);
    assign accept   = issue_valid & ~stall;

    // Clear first, then set: a new owner issued on the retiring edge keeps the bit.
    always_comb begin
        busy_next = busy;
        if (wb_valid) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (accept && issue_rd != '0) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_ones(busy_next);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == 2) ? SP_VAL : '0;
            end
        end else if (wb_valid && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: vector table on the forwarding instance,
// hand sequences comparing forwarding and non-forwarding instances side by side.
module tb_regfile_scoreboard;

    localparam int AW = 5;
    localparam logic [31:0] SP = 32'h0100_0000;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AW-1:0] rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic          issue_valid, wb_valid;
    logic [31:0]   wb_data;

    logic [31:0]   b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
    logic          b_stall, b_rs1_busy, b_rs2_busy, n_stall, n_rs1_busy, n_rs2_busy;
    logic [AW:0]   b_count, n_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(.BYPASS(1)) u_byp (
        .clock(clock), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .stall(b_stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy), .busy_count(b_count)
    );

    regfile_scoreboard #(.BYPASS(0)) u_nobyp (
        .clock(clock), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .stall(n_stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy), .busy_count(n_count)
    );

    typedef struct {
        logic          wb_valid;
        logic [AW-1:0] wb_rd;
        logic [31:0]   wb_data;
        logic          issue_valid;
        logic [AW-1:0] issue_rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [31:0]   exp_rs1_data;
        logic [31:0]   exp_rs2_data;
        logic          exp_stall;
        logic          exp_rs1_busy;
        logic          exp_rs2_busy;
        logic [AW:0]   exp_count;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = '0; wb_data = '0;
        issue_valid = 0; issue_rd = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        step();
        step();
        reset_n = 1;
    endtask

    task automatic issue_one(input logic [AW-1:0] rd);
        issue_valid = 1; issue_rd = rd;
        step();
        issue_valid = 0; issue_rd = '0;
    endtask

    initial begin
        vecs[0] = '{1, 5, 32'h55, 0, 0, 5, 2, 32'h55, SP, 0, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 1, 3, 5, 0, 32'h55, 0, 0, 0, 0, 1};
        vecs[2] = '{0, 0, 0, 1, 4, 3, 5, 0, 32'h55, 1, 1, 0, 1};
        vecs[3] = '{0, 0, 0, 1, 3, 5, 6, 32'h55, 0, 1, 0, 0, 1};
        vecs[4] = '{1, 3, 32'hA, 1, 6, 6, 3, 0, 32'hA, 0, 0, 0, 1};
        vecs[5] = '{0, 0, 0, 1, 7, 0, 6, 0, 0, 1, 0, 1, 1};
        vecs[6] = '{1, 6, 32'h66, 0, 0, 6, 3, 32'h66, 32'hA, 0, 0, 0, 0};
        vecs[7] = '{1, 0, 32'h1234, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 6, 0, 32'h66, 0, 0, 0, 0};

        reset_n = 0;
        idle();
        do_reset();

        // Post-reset state
        rs1_addr = 2; rs2_addr = 5;
        #1;
        check("reset_rs1_sp", b_rs1_data, SP);
        check("reset_rs2_zero", b_rs2_data, 0);
        check("reset_count", 32'(b_count), 0);
        check("reset_stall", 32'(b_stall), 0);
        check("reset_nobyp_sp", n_rs1_data, SP);

        // Vector table on the forwarding instance
        for (int i = 0; i < 9; i++) begin
            wb_valid = vecs[i].wb_valid; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
            issue_valid = vecs[i].issue_valid; issue_rd = vecs[i].issue_rd;
            rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2;
            #1;
            check($sformatf("v%0d_rs1_data", i), b_rs1_data, vecs[i].exp_rs1_data);
            check($sformatf("v%0d_rs2_data", i), b_rs2_data, vecs[i].exp_rs2_data);
            check($sformatf("v%0d_stall", i), 32'(b_stall), 32'(vecs[i].exp_stall));
            check($sformatf("v%0d_rs1_busy", i), 32'(b_rs1_busy), 32'(vecs[i].exp_rs1_busy));
            check($sformatf("v%0d_rs2_busy", i), 32'(b_rs2_busy), 32'(vecs[i].exp_rs2_busy));
            step();
            check($sformatf("v%0d_count", i), 32'(b_count), 32'(vecs[i].exp_count));
        end
        idle();

        // RAW hazard resolved by writeback, with and without forwarding
        do_reset();
        issue_one(3);
        check("raw_count_issue", 32'(b_count), 1);
        issue_valid = 1; issue_rd = 8; rs1_addr = 3;
        #1;
        check("raw_b_stall", 32'(b_stall), 1);
        check("raw_b_rs1_busy", 32'(b_rs1_busy), 1);
        check("raw_n_stall", 32'(n_stall), 1);
        step();
        wb_valid = 1; wb_rd = 3; wb_data = 32'hDEAD_BEEF;
        #1;
        check("raw_wb_b_stall", 32'(b_stall), 0);
        check("raw_wb_b_rs1", b_rs1_data, 32'hDEAD_BEEF);
        check("raw_wb_b_busy", 32'(b_rs1_busy), 0);
        check("raw_wb_n_stall", 32'(n_stall), 1);
        check("raw_wb_n_rs1_old", n_rs1_data, 0);
        check("raw_wb_n_busy", 32'(n_rs1_busy), 1);
        step();
        wb_valid = 0; wb_rd = '0; wb_data = '0;
        #1;
        check("raw_b_count", 32'(b_count), 1);
        check("raw_n_count", 32'(n_count), 0);
        check("raw_after_n_stall", 32'(n_stall), 0);
        check("raw_after_n_rs1", n_rs1_data, 32'hDEAD_BEEF);
        check("raw_after_b_waw_stall", 32'(b_stall), 1);
        check("raw_after_b_rs1", b_rs1_data, 32'hDEAD_BEEF);
        idle();
        step();

        // Retire and reissue the same register on one edge
        do_reset();
        issue_one(7);
        wb_valid = 1; wb_rd = 7; wb_data = 32'h77;
        issue_valid = 1; issue_rd = 7;
        #1;
        check("same_b_stall", 32'(b_stall), 0);
        check("same_n_stall", 32'(n_stall), 1);
        step();
        idle();
        rs1_addr = 7;
        #1;
        check("same_b_count", 32'(b_count), 1);
        check("same_b_busy", 32'(b_rs1_busy), 1);
        check("same_b_data", b_rs1_data, 32'h77);
        check("same_n_count", 32'(n_count), 0);
        check("same_n_data", n_rs1_data, 32'h77);

        // Reset in the middle of pending ownership, with a same-edge writeback
        do_reset();
        issue_one(1);
        issue_one(4);
        issue_one(9);
        check("pre_reset_count", 32'(b_count), 3);
        reset_n = 0;
        wb_valid = 1; wb_rd = 5; wb_data = 32'hBAD;
        issue_valid = 1; issue_rd = 10;
        step();
        reset_n = 1;
        idle();
        rs1_addr = 2; rs2_addr = 5;
        #1;
        check("rst_count", 32'(b_count), 0);
        check("rst_sp", b_rs1_data, SP);
        check("rst_wb_dropped", b_rs2_data, 0);
        issue_valid = 1; issue_rd = 1; rs1_addr = 4; rs2_addr = 9;
        #1;
        check("rst_stall", 32'(b_stall), 0);
        check("rst_n_stall", 32'(n_stall), 0);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
